// File: rtl/axi_mem_rd_responder.sv
// AXI4 read-channel responder in front of a synchronous word SRAM.
// Accepts one AR burst at a time, classifies it once, and streams the
// R beats at up to one per cycle with a configurable first-beat latency.
module axi_mem_rd_responder #(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned LATENCY  = 0,
  parameter int unsigned ID_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [ID_W-1:0]   arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic [ID_W-1:0]   rid,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DATA} state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  BURST_RSVD  = 2'b11;
  localparam logic [32:0] MEM_SPAN    = 33'(64'd4 << MEM_AW);
  localparam logic [7:0]  WAIT_LOAD   = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [1:0]        resp_q, resp_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        wait_q, wait_d;

  logic [32:0]       ar_off;
  logic [1:0]        ar_resp;
  logic              ar_unaligned;
  logic              wrap_len_ok;
  logic              last_beat;
  logic [31:0]       step;
  logic [31:0]       wrap_mask;
  logic [31:0]       addr_nxt;
  logic [31:0]       mem_byte;

  assign arready   = (state_q == S_IDLE) && reset;
  assign rvalid    = (state_q == S_DATA);
  assign last_beat = (beat_q == len_q);
  assign rlast     = rvalid && last_beat;
  assign rresp     = resp_q;
  assign rid       = id_q;
  assign rdata     = (rvalid && resp_q == RESP_OKAY) ? mem_rdata : '0;
  assign mem_addr  = MEM_AW'((mem_byte - MEM_BASE) >> 2);

  // Classify the incoming request: protocol errors take priority over range errors.
  always_comb begin
    ar_off       = {1'b0, araddr} - {1'b0, MEM_BASE};
    ar_unaligned = (arsize == 3'd1 && araddr[0]) || (arsize == 3'd2 && araddr[1:0] != 2'b00);
    wrap_len_ok  = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
    ar_resp      = RESP_OKAY;
    if (arsize > 3'd2 || arburst == BURST_RSVD) begin
      ar_resp = RESP_SLVERR;
    end else if (arburst == BURST_WRAP && (!wrap_len_ok || ar_unaligned)) begin
      ar_resp = RESP_SLVERR;
    end else if (ar_off >= MEM_SPAN) begin
      ar_resp = RESP_DECERR;
    end
  end

  // Address of the following beat for the latched burst type.
  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:     addr_nxt = addr_q + step;
    endcase
  end

  // Next-state and SRAM strobe; the next beat's read is issued on the
  // current beat's handshake so the data is ready one cycle later.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    resp_d   = resp_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    mem_en   = 1'b0;
    mem_byte = addr_q;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready) begin
          addr_d  = araddr;
          id_d    = arid;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          resp_d  = ar_resp;
          beat_d  = '0;
          wait_d  = WAIT_LOAD;
          state_d = (LATENCY > 0) ? S_WAIT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_ISSUE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_ISSUE: begin
        mem_en  = (resp_q == RESP_OKAY);
        state_d = S_DATA;
      end
      S_DATA: begin
        if (rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            addr_d   = addr_nxt;
            beat_d   = beat_q + 8'd1;
            mem_en   = (resp_q == RESP_OKAY);
            mem_byte = addr_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and burst context registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      resp_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      resp_q  <= resp_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_rd_responder.sv
// Bench for axi_mem_rd_responder: two instances (LATENCY 0 and 5) share an
// SRAM image; a burst-level model predicts every output each cycle.
module tb_axi_mem_rd_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned AW   = 8;
  localparam int unsigned NW   = 256;
  localparam int          LAT0 = 0;
  localparam int          LAT1 = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       arvalid, rready;
  logic [1:0][31:0] araddr, mem_rdata;
  logic [1:0][3:0]  arid;
  logic [1:0][7:0]  arlen;
  logic [1:0][2:0]  arsize;
  logic [1:0][1:0]  arburst;
  wire  [1:0]       arready, rvalid, rlast, mem_en;
  wire  [1:0][31:0] rdata;
  wire  [1:0][1:0]  rresp;
  wire  [1:0][3:0]  rid;
  wire  [1:0][7:0]  mem_addr;

  axi_mem_rd_responder #(.MEM_BASE(BASE), .MEM_AW(AW), .LATENCY(LAT0), .ID_W(4)) dut0 (
    .clock(clk), .reset(rst_n), .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
    .arid(arid[0]), .arlen(arlen[0]), .arsize(arsize[0]), .arburst(arburst[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]), .rlast(rlast[0]),
    .rid(rid[0]), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]));

  axi_mem_rd_responder #(.MEM_BASE(BASE), .MEM_AW(AW), .LATENCY(LAT1), .ID_W(4)) dut1 (
    .clock(clk), .reset(rst_n), .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
    .arid(arid[1]), .arlen(arlen[1]), .arsize(arsize[1]), .arburst(arburst[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]), .rlast(rlast[1]),
    .rid(rid[1]), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [31:0] sram [NW];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data appears the cycle after the strobe and holds otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_en[k]) mem_rdata[k] <= sram[mem_addr[k]];
  end

  // Burst-level model state per instance.
  bit          busy [2];
  int          first [2];
  int          m_beat [2];
  logic [31:0] m_addr [2];
  logic [7:0]  m_len [2];
  logic [2:0]  m_size [2];
  logic [1:0]  m_burst [2];
  logic [1:0]  m_resp [2];
  logic [3:0]  m_id [2];

  // Observed traffic of the most recent burst per instance.
  int          acc_cyc [2];
  int          rv_first [2];
  bit          rv_seen [2];
  int          obs_cnt [2];
  int          mem_cnt [2];
  logic [31:0] obs_data [2][16];
  logic [1:0]  obs_resp [2][16];
  logic        obs_last [2][16];
  logic [3:0]  obs_rid [2][16];
  logic [7:0]  obs_maddr [2][16];

  int rr_mode [2] = '{0, 0};
  int rr_ph [2]   = '{0, 0};

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [1:0] spec_resp(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    int n = int'(len) + 1;
    if (size > 3'd2 || burst == 2'b11) return 2'b10;
    if (burst == 2'b10) begin
      if (n != 2 && n != 4 && n != 8 && n != 16) return 2'b10;
      if (a % (32'd1 << size) != 32'd0) return 2'b10;
    end
    if ({32'd0, a} < {32'd0, BASE} || {32'd0, a} >= {32'd0, BASE} + 64'(4 * NW)) return 2'b11;
    return 2'b00;
  endfunction

  // Byte address of beat i, computed directly from the start address.
  function automatic logic [31:0] beat_addr(input int k, input int i);
    logic [31:0] a    = m_addr[k];
    logic [31:0] step = 32'd1 << m_size[k];
    logic [31:0] w, lo;
    case (m_burst[k])
      2'b00: return a;
      2'b10: begin
        w  = (32'(m_len[k]) + 32'd1) * step;
        lo = a - (a % w);
        return lo + ((a - lo + 32'(i) * step) % w);
      end
      default: return a + 32'(i) * step;
    endcase
  endfunction

  function automatic logic [7:0] word_of(input logic [31:0] a);
    return 8'((a - BASE) >> 2);
  endfunction

  task automatic check_one(input int k);
    logic exp_rv, exp_men, hs;
    logic [31:0] ba;
    if (!rst_n) begin
      chk("reset_outs", k, {arready[k], rvalid[k], rlast[k], rresp[k], rid[k], mem_en[k]}, '0);
      busy[k] = 1'b0;
      return;
    end
    exp_rv = busy[k] && (cyc >= first[k]);
    chk("arready", k, arready[k], !busy[k]);
    chk("rvalid", k, rvalid[k], exp_rv);
    if (exp_rv) begin
      ba = beat_addr(k, m_beat[k]);
      chk("rdata", k, rdata[k], (m_resp[k] == 2'b00) ? sram[word_of(ba)] : 32'd0);
      chk("rresp", k, rresp[k], m_resp[k]);
      chk("rlast", k, rlast[k], m_beat[k] == int'(m_len[k]));
      chk("rid", k, rid[k], m_id[k]);
    end
    hs = exp_rv && rready[k];
    exp_men = busy[k] && (m_resp[k] == 2'b00) &&
              ((cyc == first[k] - 1) || (hs && m_beat[k] != int'(m_len[k])));
    chk("mem_en", k, mem_en[k], exp_men);
    if (mem_en[k] && exp_men)
      chk("mem_addr", k, mem_addr[k], word_of(beat_addr(k, hs ? m_beat[k] + 1 : m_beat[k])));

    if (mem_en[k]) begin
      if (mem_cnt[k] < 16) obs_maddr[k][mem_cnt[k]] = mem_addr[k];
      mem_cnt[k]++;
    end
    if (rvalid[k] && !rv_seen[k]) begin
      rv_seen[k]  = 1'b1;
      rv_first[k] = cyc;
    end
    if (rvalid[k] && rready[k]) begin
      if (obs_cnt[k] < 16) begin
        obs_data[k][obs_cnt[k]] = rdata[k];
        obs_resp[k][obs_cnt[k]] = rresp[k];
        obs_last[k][obs_cnt[k]] = rlast[k];
        obs_rid[k][obs_cnt[k]]  = rid[k];
      end
      obs_cnt[k]++;
    end

    if (hs) begin
      if (m_beat[k] == int'(m_len[k])) busy[k] = 1'b0;
      else m_beat[k]++;
    end else if (!busy[k] && arvalid[k]) begin
      m_addr[k]  = araddr[k];
      m_len[k]   = arlen[k];
      m_size[k]  = arsize[k];
      m_burst[k] = arburst[k];
      m_id[k]    = arid[k];
      m_resp[k]  = spec_resp(araddr[k], arlen[k], arsize[k], arburst[k]);
      m_beat[k]  = 0;
      busy[k]    = 1'b1;
      first[k]   = cyc + 2 + lat_of(k);
      acc_cyc[k] = cyc;
      rv_seen[k] = 1'b0;
      obs_cnt[k] = 0;
      mem_cnt[k] = 0;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) check_one(k);
  end

  // rready policy: 0 = always, 1 = random, 2 = pattern 1,0,0 repeating.
  initial begin
    rready = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rr_mode[k])
          0:       rready[k] = 1'b1;
          1:       rready[k] = 1'($urandom_range(0, 1));
          default: rready[k] = (rr_ph[k] % 3 == 0);
        endcase
        rr_ph[k]++;
      end
    end
  end

  task automatic send_ar(input int k, input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    arvalid[k] = 1'b1;
    araddr[k]  = a;
    arid[k]    = id;
    arlen[k]   = len;
    arsize[k]  = size;
    arburst[k] = burst;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = arready[k];
      @(posedge clk);
      #1;
    end
    arvalid[k] = 1'b0;
    chk("ar_accept", k, ok, 1);
  endtask

  task automatic wait_idle(input int k);
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = !busy[k];
    end
    chk("r_done", k, ok, 1);
  endtask

  task automatic run_txn(input int k, input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    send_ar(k, a, id, len, size, burst);
    wait_idle(k);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          r;
    logic [31:0] wv [4];

    for (int i = 0; i < int'(NW); i++) sram[i] = $urandom;
    arvalid = '0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single INCR beat, zero latency.
    sram[4] = 32'hDEAD_BEEF;
    rr_mode[0] = 0;
    run_txn(0, 32'h8000_0010, 4'h5, 8'd0, 3'd2, 2'b01);
    chk("t1_latency", 0, rv_first[0] - acc_cyc[0], 2);
    chk("t1_beats", 0, obs_cnt[0], 1);
    chk("t1_data", 0, obs_data[0][0], 32'hDEAD_BEEF);
    chk("t1_resp_last_id", 0, {obs_resp[0][0], obs_last[0][0], obs_rid[0][0]}, {2'b00, 1'b1, 4'h5});

    // WRAP refill starting at the last word of a 16-byte line.
    wv[0] = 32'hAAAA_0000; wv[1] = 32'hBBBB_1111; wv[2] = 32'hCCCC_2222; wv[3] = 32'hDDDD_3333;
    for (int i = 0; i < 4; i++) sram[i] = wv[i];
    run_txn(0, 32'h8000_000C, 4'h3, 8'd3, 3'd2, 2'b10);
    chk("t2_beats", 0, obs_cnt[0], 4);
    chk("t2_d0", 0, obs_data[0][0], 32'hDDDD_3333);
    chk("t2_d1", 0, obs_data[0][1], 32'hAAAA_0000);
    chk("t2_d2", 0, obs_data[0][2], 32'hBBBB_1111);
    chk("t2_d3", 0, obs_data[0][3], 32'hCCCC_2222);
    chk("t2_last", 0, {obs_last[0][0], obs_last[0][1], obs_last[0][2], obs_last[0][3]}, 4'b0001);
    chk("t2_maddr", 0, {obs_maddr[0][0], obs_maddr[0][1], obs_maddr[0][2], obs_maddr[0][3]},
        {8'd3, 8'd0, 8'd1, 8'd2});

    // INCR x8 with a stalling initiator.
    rr_mode[0] = 2;
    rr_ph[0]   = 0;
    run_txn(0, BASE + 32'h40, 4'h9, 8'd7, 3'd2, 2'b01);
    chk("t3_beats", 0, obs_cnt[0], 8);
    chk("t3_mem_en_pulses", 0, mem_cnt[0], 8);
    for (int i = 0; i < 8; i++) chk("t3_data", 0, obs_data[0][i], sram[16 + i]);

    // Decode error, then an unsupported size.
    rr_mode[0] = 1;
    run_txn(0, 32'h0000_1000, 4'h2, 8'd1, 3'd2, 2'b01);
    chk("t4_beats", 0, obs_cnt[0], 2);
    chk("t4_resp", 0, {obs_resp[0][0], obs_resp[0][1]}, 4'b1111);
    chk("t4_data", 0, {obs_data[0][0], obs_data[0][1]}, 64'd0);
    chk("t4_last", 0, {obs_last[0][0], obs_last[0][1]}, 2'b01);
    chk("t4_no_mem", 0, mem_cnt[0], 0);
    run_txn(0, BASE, 4'h1, 8'd3, 3'd3, 2'b01);
    chk("t4b_beats", 0, obs_cnt[0], 4);
    chk("t4b_resp", 0, {obs_resp[0][0], obs_resp[0][1], obs_resp[0][2], obs_resp[0][3]}, 8'hAA);
    chk("t4b_no_mem", 0, mem_cnt[0], 0);

    // Top of the SRAM window and the first byte past it.
    run_txn(0, BASE + 32'h3FC, 4'h4, 8'd0, 3'd2, 2'b01);
    chk("edge_in_resp", 0, obs_resp[0][0], 2'b00);
    run_txn(0, BASE + 32'h400, 4'h4, 8'd0, 3'd2, 2'b01);
    chk("edge_out_resp", 0, obs_resp[0][0], 2'b11);

    // Asynchronous reset during beat 2 of 4.
    rr_mode[0] = 0;
    send_ar(0, BASE + 32'h80, 4'h7, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 50 && obs_cnt[0] < 1; i++) begin
      @(negedge clk);
      #1;
    end
    chk("t5_beat1_seen", 0, obs_cnt[0], 1);
    @(posedge clk);
    #3;
    chk("t5_rvalid_before", 0, rvalid[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid_drop", 0, {rvalid[0], rlast[0], mem_en[0]}, 3'b000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t5_arready", 0, arready[0], 1);
    run_txn(0, BASE + 32'h84, 4'hB, 8'd1, 3'd2, 2'b01);
    chk("t5_fresh_beats", 0, obs_cnt[0], 2);
    chk("t5_fresh_d1", 0, obs_data[0][1], sram[34]);

    // Five-cycle latency instance.
    rr_mode[1] = 0;
    run_txn(1, BASE + 32'h20, 4'hA, 8'd3, 3'd2, 2'b01);
    chk("t6_latency", 1, rv_first[1] - acc_cyc[1], 7);
    chk("t6_beats", 1, obs_cnt[1], 4);

    // Randomized bursts on both instances, checked cycle by cycle.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 60; n++) begin
        rr_mode[k] = $urandom_range(0, 2);
        r = $urandom_range(0, 9);
        burst = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r < 8) ? 2'b00 : 2'b11;
        size  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        if (burst == 2'b10 && $urandom_range(0, 9) < 8) begin
          r   = $urandom_range(0, 3);
          len = 8'((2 << r) - 1);
        end else begin
          len = 8'($urandom_range(0, 15));
        end
        r = $urandom_range(0, 9);
        if (r < 8)      a = BASE + 32'($urandom_range(0, 1023));
        else if (r < 9) a = BASE + 32'h400 - 32'($urandom_range(0, 8)) + 32'($urandom_range(0, 8));
        else            a = $urandom;
        if (size <= 3'd2 && $urandom_range(0, 9) < 9) a = a & ~((32'd1 << size) - 32'd1);
        sram[$urandom_range(0, NW - 1)] = $urandom;
        run_txn(k, a, 4'($urandom_range(0, 15)), len, size, burst);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_mem_rd_responder.md
Name: axi_mem_rd_responder

Overview:
- AXI4 read-channel responder (slave) for the instruction and data memory in simulation and FPGA builds.
- The fetch-side ICache is its initiator: AR requests, including wrap refills, arrive here.
- Turns AR bursts into word reads on a synchronous SRAM port and returns R beats with configurable first-beat latency.
- Out-of-range and unsupported requests get AXI error responses.

Parameters:
- MEM_BASE, 32'h80000000, byte base address of the backing SRAM
- MEM_AW, 16, SRAM word-address width (capacity 4*2^MEM_AW bytes)
- LATENCY, 0, extra wait cycles between AR accept and first SRAM read (0..255)
- ID_W, 4, AXI ID width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- arvalid  in  1  AR request valid
- arready  out  1  AR accept
- araddr  in  32  byte address
- arid  in  ID_W  transaction ID
- arlen  in  8  beats minus 1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- rvalid  out  1  R beat valid
- rready  in  1  R beat accept
- rdata  out  32  beat data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  final beat
- rid  out  ID_W  echoed arid
- mem_en  out  1  SRAM read strobe
- mem_addr  out  MEM_AW  SRAM word address
- mem_rdata  in  32  SRAM data, valid the cycle after mem_en, held until the next mem_en

Behaviour:
- Reset is asynchronous and active-low, applied via the reset port.
- While reset is asserted: state=IDLE, arready=0, rvalid=0, rlast=0, rresp=00, rid=0, mem_en=0, and all counters are cleared.
- Reset mid-burst abandons the burst silently; no further beats are sent.
- Only one transaction is outstanding at a time.
- IDLE:
  - arready=1 from the first cycle after reset release.
  - On arvalid&arready: latch addr, id, len, size, burst; clear beat counter; classify the request.
  - Go to WAIT if LATENCY>0, else go to ISSUE.
- Classification:
  - arsize>2, or burst 11, or WRAP with len+1 not in {2,4,8,16}, or WRAP with unaligned addr -> SLVERR.
  - Else, address outside [MEM_BASE, MEM_BASE+4*2^MEM_AW) -> DECERR.
  - Else -> OKAY.
  - Classification is done once per burst; the rresp of every beat equals it.
- WAIT: counts LATENCY cycles, then goes to ISSUE. arready=0.
- ISSUE (one cycle):
  - mem_en=1 only if classification is OKAY.
  - mem_addr = (addr-MEM_BASE)[MEM_AW+1:2].
  - Go to DATA.
- DATA:
  - rvalid=1.
  - rdata = mem_rdata for OKAY, else 0.
  - rlast = (beat==len).
  - rid = latched id.
  - rvalid, rdata, rresp, rlast, and rid are stable while rready=0; mem_en=0 while stalled.
  - On handshake with !rlast: advance addr, beat++, and assert mem_en for the next beat in the same cycle; stay in DATA. Sustained rready gives 1 beat/cycle.
  - On handshake with rlast: go to IDLE; arready=1 the next cycle.
- Address advance, with step = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+step, 32-bit wrap, no 4KB check.
  - WRAP: with boundary W=(len+1)*step, addr = (addr & ~(W-1)) | ((addr+step) & (W-1)).
- Sub-word sizes return the full aligned word; the initiator selects the lanes.
- Latency from AR handshake at cycle T: first rvalid at T+2+LATENCY.
- A new AR can be accepted no earlier than 1 cycle after the last R handshake (no back-to-back overlap).

Test Plan:
- LATENCY=0, INCR single beat at 0x80000010, SRAM word 4 = 0xDEADBEEF, rready=1 -> rvalid at T+2, rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid.
- WRAP len=3 size=2 at 0x8000000C, words 0..3 = A,B,C,D -> beats D,A,B,C; rlast on beat 4; mem_addr sequence 3,0,1,2.
- INCR len=7 with rready toggled 1,0,0,1... -> no beat lost or duplicated; outputs held while stalled; mem_en pulses exactly 8 times.
- araddr=0x00001000 len=1 -> 2 beats, rresp=11, rdata=0, rlast on beat 2, mem_en never asserted; arsize=3 -> rresp=10 for all beats.
- LATENCY=5 -> first rvalid at T+7; arready low from T+1 until the cycle after the last beat.
- Reset asserted asynchronously mid-burst at beat 2 of 4 -> rvalid drops immediately; after release arready=1 and a fresh request completes correctly.
